// File: rtl/axi_mem_slave.sv
// AXI3 slave memory: byte-addressed RAM of 2^ADDR_LENGTH bytes with independent
// write (AW/W/B) and read (AR/R) channel state machines.
module axi_mem_slave #(
    parameter int unsigned AXI_WIDTH_CID = 0,
    parameter int unsigned AXI_WIDTH_ID  = 4,
    parameter int unsigned AXI_WIDTH_AD  = 32,
    parameter int unsigned AXI_WIDTH_DA  = 32,
    parameter int unsigned AXI_WIDTH_DS  = AXI_WIDTH_DA / 8,
    parameter int unsigned ADDR_LENGTH   = 12,
    localparam int unsigned W_SID        = AXI_WIDTH_CID + AXI_WIDTH_ID
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [W_SID-1:0]        AWID,
    input  logic [AXI_WIDTH_AD-1:0] AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [1:0]              AWLOCK,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [W_SID-1:0]        WID,
    input  logic [AXI_WIDTH_DA-1:0] WDATA,
    input  logic [AXI_WIDTH_DS-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [W_SID-1:0]        BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [W_SID-1:0]        ARID,
    input  logic [AXI_WIDTH_AD-1:0] ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [1:0]              ARLOCK,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [W_SID-1:0]        RID,
    output logic [AXI_WIDTH_DA-1:0] RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    CSYSREQ,
    output logic                    CSYSACK,
    output logic                    CACTIVE
);

    localparam int unsigned SizeMax  = $clog2(AXI_WIDTH_DS);
    localparam int unsigned MemBytes = 1 << ADDR_LENGTH;
    localparam logic [ADDR_LENGTH-1:0] LaneMask = ADDR_LENGTH'(AXI_WIDTH_DS - 1);

    typedef logic [AXI_WIDTH_AD-1:0] addr_t;
    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic {RIdle, RData} rstate_e;

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        logic [2:0] res;
        res = size;
        if (32'(size) > SizeMax) res = 3'(SizeMax);
        return res;
    endfunction

    // WRAP keeps the address inside the (len+1)*step aligned window.
    function automatic addr_t next_addr(input addr_t addr, input logic [3:0] len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t step, inc, mask, res;
        step = addr_t'(1) << size;
        inc  = addr + step;
        mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
        case (burst)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~mask) | (inc & mask);
            default: res = inc;
        endcase
        return res;
    endfunction

    // Contents survive reset; zero only at time 0.
    logic [7:0] mem_q [MemBytes] = '{default: 8'h00};

    wstate_e           wstate_q, wstate_d;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [W_SID-1:0]  wid_q, wid_d, bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d, wburst_q, wburst_d;
    addr_t             waddr_q, waddr_d;
    logic [3:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]        wsize_q, wsize_d;
    logic              werr_q, werr_d;
    logic              w_fire, w_last_beat, w_mismatch;
    logic [ADDR_LENGTH-1:0] wbase;

    rstate_e           rstate_q, rstate_d;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [W_SID-1:0]  rid_q, rid_d;
    logic [AXI_WIDTH_DA-1:0] rdata_q, rdata_d, rd_word;
    addr_t             raddr_q, raddr_d, raddr_nxt, rd_addr;
    logic [3:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [ADDR_LENGTH-1:0] rbase;

    logic csysack_q, cactive_q;
    logic unused_ok;

    assign w_fire      = (wstate_q == WData) && WVALID && wready_q;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_mismatch  = (WLAST != w_last_beat);
    assign wbase       = waddr_q[ADDR_LENGTH-1:0] & ~LaneMask;

    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        case (wstate_q)
            WIdle: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wid_d     = AWID;
                    waddr_d   = AWADDR;
                    wlen_d    = AWLEN;
                    wsize_d   = clamp_size(AWSIZE);
                    wburst_d  = AWBURST;
                    wcnt_d    = 4'd0;
                    werr_d    = 1'b0;
                    wstate_d  = WData;
                end
            end
            WData: begin
                if (w_fire) begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 4'd1;
                    werr_d  = werr_q | w_mismatch;
                    // Burst length comes from AWLEN only; WLAST just grades the response.
                    if (w_last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        bresp_d  = (werr_q | w_mismatch) ? 2'b10 : 2'b00;
                        wstate_d = WResp;
                    end
                end
            end
            WResp: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wstate_q  <= WIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= 4'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'b00;
            wcnt_q    <= 4'd0;
            werr_q    <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_fire) begin
            for (int i = 0; i < int'(AXI_WIDTH_DS); i++) begin
                if (WSTRB[i]) mem_q[wbase + ADDR_LENGTH'(i)] <= WDATA[8*i +: 8];
            end
        end
    end

    assign raddr_nxt = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    assign rd_addr   = (rstate_q == RIdle) ? ARADDR : raddr_nxt;
    assign rbase     = rd_addr[ADDR_LENGTH-1:0] & ~LaneMask;

    // Registered read of the word at rd_addr sees pre-write contents on a collision.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(AXI_WIDTH_DS); i++) begin
            rd_word[8*i +: 8] = mem_q[rbase + ADDR_LENGTH'(i)];
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        case (rstate_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rid_d     = ARID;
                    rlast_d   = (ARLEN == 4'd0);
                    raddr_d   = ARADDR;
                    rlen_d    = ARLEN;
                    rsize_d   = clamp_size(ARSIZE);
                    rburst_d  = ARBURST;
                    rcnt_d    = 4'd0;
                    rstate_d  = RData;
                end
            end
            RData: begin
                if (rvalid_q && RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        rstate_d  = RIdle;
                    end else begin
                        raddr_d = raddr_nxt;
                        rcnt_d  = rcnt_q + 4'd1;
                        rdata_d = rd_word;
                        rlast_d = ((rcnt_q + 4'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = RIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q  <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= 4'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'b00;
            rcnt_q    <= 4'd0;
            csysack_q <= 1'b0;
            cactive_q <= 1'b0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            csysack_q <= CSYSREQ;
            cactive_q <= 1'b1;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = 2'b00;
    assign CSYSACK = csysack_q;
    assign CACTIVE = cactive_q;

    assign unused_ok = ^{AWLOCK, ARLOCK, WID, rd_addr[AXI_WIDTH_AD-1:ADDR_LENGTH]};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a byte-level memory model feeds queues of expected
// B and R responses that are popped and compared as the DUT returns them.
module tb_axi_mem_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [1:0]  AWLOCK, AWBURST, BRESP, ARLOCK, ARBURST, RRESP;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, CSYSREQ, CSYSACK, CACTIVE;

    always #5 ACLK = ~ACLK;

    axi_mem_slave #(
        .AXI_WIDTH_CID(0), .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .AXI_WIDTH_DA(32),
        .AXI_WIDTH_DS(4), .ADDR_LENGTH(12)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWLOCK(AWLOCK), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
        .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARLOCK(ARLOCK), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .CSYSREQ(CSYSREQ), .CSYSACK(CSYSACK), .CACTIVE(CACTIVE)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  model [4096];
    logic [31:0] beat_data [16];
    logic [3:0]  exp_bid_q [$];
    logic [1:0]  exp_bresp_q [$];
    logic [31:0] exp_rdata_q [$];
    logic        exp_rlast_q [$];
    logic [3:0]  exp_rid_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_next(input logic [31:0] addr, input int len,
                                            input int size, input logic [1:0] burst);
        logic [31:0] step, total, bound, res;
        step  = 32'(1) << ((size > 2) ? 2 : size);
        total = 32'(len + 1) * step;
        case (burst)
            2'b00: res = addr;
            2'b10: begin
                bound = addr - (addr % total);
                res   = bound + ((addr - bound + step) % total);
            end
            default: res = addr + step;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [11:0] base;
        logic [31:0] w;
        base = addr[11:0] & 12'hFFC;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = model[base + 12'(i)];
        return w;
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input int size, input logic [1:0] burst,
                               input logic [3:0] strb, input int last_at);
        logic [31:0] a;
        logic [11:0] base;
        int n;
        a = addr;
        exp_bid_q.push_back(id);
        exp_bresp_q.push_back((last_at != len) ? 2'b10 : 2'b00);
        AWID = id; AWADDR = addr; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = burst;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        check("aw_ready", AWREADY, 1'b1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            WID = id; WDATA = beat_data[b]; WSTRB = strb; WLAST = (b == last_at);
            WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(posedge ACLK); #1; n++; end
            check("w_ready", WREADY, 1'b1);
            base = a[11:0] & 12'hFFC;
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[base + 12'(i)] = beat_data[b][8*i +: 8];
            a = tb_next(a, len, size, burst);
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("w_ready_drop", WREADY, 1'b0);
        check("b_valid_after_last", BVALID, 1'b1);
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 50) begin @(posedge ACLK); #1; n++; end
        check("b_id", BID, exp_bid_q.pop_front());
        check("b_resp", BRESP, exp_bresp_q.pop_front());
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("b_valid_drop", BVALID, 1'b0);
        check("aw_ready_back", AWREADY, 1'b1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input int size, input logic [1:0] burst, input int stall_at);
        logic [31:0] a, ed;
        int n;
        a = addr;
        for (int b = 0; b <= len; b++) begin
            exp_rdata_q.push_back(model_word(a));
            exp_rlast_q.push_back(b == len);
            exp_rid_q.push_back(id);
            a = tb_next(a, len, size, burst);
        end
        ARID = id; ARADDR = addr; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = burst;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        check("ar_ready", ARREADY, 1'b1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        RREADY = 1'b1;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!RVALID && n < 50) begin @(posedge ACLK); #1; n++; end
            check("r_valid", RVALID, 1'b1);
            ed = exp_rdata_q.pop_front();
            check("r_data", RDATA, ed);
            check("r_last", RLAST, exp_rlast_q.pop_front());
            check("r_id", RID, exp_rid_q.pop_front());
            check("r_resp", RRESP, 2'b00);
            if (b == stall_at) begin
                RREADY = 1'b0;
                repeat (3) begin @(posedge ACLK); #1; end
                check("r_stall_data", RDATA, ed);
                check("r_stall_valid", RVALID, 1'b1);
                RREADY = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        RREADY = 1'b0;
        check("r_end", {RVALID, RLAST, ARREADY}, 3'b001);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) model[i] = 8'h00;
        ARESETn = 1'b0; CSYSREQ = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWLOCK = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARLOCK = '0; ARSIZE = '0;
        ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;

        repeat (2) @(posedge ACLK);
        #1;
        check("reset_outputs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RDATA,
                                RID, RLAST, RRESP, CSYSACK, CACTIVE}, 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("post_reset_ready", {AWREADY, ARREADY, WREADY, BVALID, RVALID}, 5'b11000);
        check("cactive", CACTIVE, 1'b1);
        check("csysack_hi", CSYSACK, 1'b1);
        CSYSREQ = 1'b0;
        @(posedge ACLK); #1;
        check("csysack_lo", CSYSACK, 1'b0);

        beat_data[0] = 32'hDEADBEEF;
        write_burst(4'h3, 32'h10, 0, 2, 2'b01, 4'hF, 0);
        read_burst(4'h5, 32'h10, 0, 2, 2'b01, 99);

        for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
        write_burst(4'h1, 32'h100, 3, 2, 2'b01, 4'hF, 3);
        read_burst(4'h2, 32'h100, 3, 2, 2'b01, 1);

        for (int i = 0; i < 4; i++) beat_data[i] = 32'hA0A0_0000 + 32'(i);
        write_burst(4'h6, 32'h208, 3, 2, 2'b10, 4'hF, 3);
        read_burst(4'h7, 32'h208, 3, 2, 2'b10, 99);
        read_burst(4'h8, 32'h200, 3, 2, 2'b01, 99);

        beat_data[0] = 32'hAABBCCDD;
        write_burst(4'h9, 32'h300, 0, 2, 2'b01, 4'h3, 0);
        read_burst(4'hA, 32'h300, 0, 2, 2'b01, 99);

        beat_data[0] = 32'h12345678;
        write_burst(4'hB, 32'h1010, 0, 2, 2'b01, 4'hF, 0);
        read_burst(4'hC, 32'h010, 0, 2, 2'b01, 99);

        for (int i = 0; i < 4; i++) beat_data[i] = 32'h5500_0000 + 32'(i);
        write_burst(4'hD, 32'h400, 3, 2, 2'b01, 4'hF, 1);
        read_burst(4'hE, 32'h400, 3, 2, 2'b01, 99);

        beat_data[0] = 32'h11111111; beat_data[1] = 32'h22222222;
        write_burst(4'h4, 32'h600, 1, 2, 2'b00, 4'hF, 1);
        read_burst(4'h4, 32'h600, 0, 2, 2'b01, 99);

        beat_data[0] = 32'hCAFE0001; beat_data[1] = 32'hCAFE0002;
        fork
            write_burst(4'hF, 32'h500, 1, 2, 2'b01, 4'hF, 1);
            read_burst(4'h0, 32'h100, 3, 2, 2'b01, 99);
        join
        read_burst(4'h1, 32'h500, 1, 2, 2'b01, 99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
